cache_arbiter: RTL

Responder-side endpoint for the L1 cache miss protocol: accepts level-held line requests from the instruction cache (read only) and the data cache (read or write-back), serialises them onto the single L2 port, and returns a one-cycle response to the requester that was granted. Sits between the two L1 cache controllers and the L2 cache. From the L1 side it behaves exactly as L2 does: the requester holds its strobe until it sees resp.

---
 rtl/cache_arbiter.sv | 70 +++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises icache/dcache line requests onto a single L2 port,
// alternating grants on ties and inserting one RECOVER cycle after each response.
module cache_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic         icache_read,
  input  logic [15:0]  icache_address,
  output logic [127:0] icache_rdata,
  output logic         icache_resp,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  logic [15:0]  dcache_address,
  input  logic [127:0] dcache_wdata,
  output logic [127:0] dcache_rdata,
  output logic         dcache_resp,
  output logic         L2_read,
  output logic         L2_write,
  output logic [15:0]  L2_address,
  output logic [127:0] L2_wdata,
  input  logic [127:0] L2_rdata,
  input  logic         L2_resp
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RECOVER} state_e;
  state_e       state_q;
  logic         last_dcache_q;
  logic         wr_q;
  logic [15:0]  addr_q;
  logic [127:0] wdata_q;
  logic         dreq, pick_dcache, busy;
  assign dreq        = dcache_read | dcache_write;
  // On a tie, the requester not granted last time wins.
  assign pick_dcache = dreq & (~icache_read | ~last_dcache_q);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      last_dcache_q <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_dcache) begin
            state_q       <= D_BUSY;
            wr_q          <= dcache_write;
            addr_q        <= dcache_address;
            last_dcache_q <= 1'b1;
            if (dcache_write) wdata_q <= dcache_wdata;
          end else if (icache_read) begin
            state_q       <= I_BUSY;
            wr_q          <= 1'b0;
            addr_q        <= icache_address;
            last_dcache_q <= 1'b0;
          end
        end
        I_BUSY, D_BUSY: if (L2_resp) state_q <= RECOVER;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy         = (state_q == I_BUSY) || (state_q == D_BUSY);
  assign L2_read      = busy & ~wr_q;
  assign L2_write     = busy & wr_q;
  assign L2_address   = addr_q;
  assign L2_wdata     = wdata_q;
  assign icache_resp  = (state_q == I_BUSY) & L2_resp;
  assign dcache_resp  = (state_q == D_BUSY) & L2_resp;
  assign icache_rdata = L2_rdata;
  assign dcache_rdata = L2_rdata;
endmodule
